// File: rtl/pwm_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder_if
// Purpose  : Bundles the PWM input and the duty/period measurement outputs
//            of pwm_decoder into one connection.
// Signals  : pwm_in     - raw asynchronous PWM waveform
//            duty_cycle - last measured duty, 0..100 percent
//            period     - last measured period in clk cycles, 0 after timeout
//            valid      - one-cycle pulse when duty_cycle/period update
//            overrun    - one-cycle pulse when a period is dropped
// Modports : master - source of pwm_in, consumer of measurements
//            slave  - the decoder itself
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_decoder_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [6:0]       duty_cycle;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             overrun;

  modport master (
    output pwm_in,
    input  duty_cycle,
    input  period,
    input  valid,
    input  overrun
  );

  modport slave (
    input  pwm_in,
    output duty_cycle,
    output period,
    output valid,
    output overrun
  );
endinterface
`default_nettype wire

// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder
// Purpose  : Measures period and high time of an asynchronous PWM input and
//            reports the duty cycle as floor(H*100/P), clamped to 100, using a
//            sequential restoring divider. A stuck input is reported through a
//            timeout that yields 0 % or 100 % with period 0.
// Ports    : clk   - system clock, all logic on posedge
//            clr_n - asynchronous active-low clear
//            bus   - pwm_decoder_if.slave (pwm_in in; duty_cycle, period,
//                    valid, overrun out)
// Revision : 1.0 - initial release
// ============================================================================
module pwm_decoder #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  pwm_decoder_if.slave bus
);

  localparam int               NW        = CNT_W + 7;       // dividend width
  localparam int               SW        = $clog2(NW + 1);  // step counter width
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [SW-1:0]    LAST_STEP = SW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic [NW-1:0]    dividend;   // shifts out dividend bits, shifts in quotient
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] divisor;
  logic [SW-1:0]    step;
  logic [6:0]       duty_cycle;
  logic [CNT_W-1:0] period;
  logic             valid, overrun;

  logic             rise, timeout, fits;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W-1:0] rem_nx;
  logic [NW-1:0]    quo_nx;
  logic [6:0]       duty_sat;

  // A falling edge needs no explicit detector: hcnt simply stops counting
  // while s2 is low, so an unreferenced fall has no effect.
  assign rise    = s2 & ~s3;
  assign timeout = (state != DIVIDE) && (pcnt == CNT_MAX) && !rise;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Both counters restart at 1 on a rise so that, at the next rise, pcnt is
  // the rise-to-rise distance and hcnt includes the rise cycle itself.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pcnt <= '0;
      hcnt <= '0;
    end else begin
      if (rise)
        pcnt <= CNT_W'(1);
      else if (timeout)
        pcnt <= '0;
      else if (pcnt != CNT_MAX)
        pcnt <= pcnt + CNT_W'(1);

      if (rise)
        hcnt <= CNT_W'(1);
      else if (s2 && (hcnt != CNT_MAX))
        hcnt <= hcnt + CNT_W'(1);
    end
  end

  // One restoring-division step. The remainder always stays below the
  // divisor, so the subtraction result fits in CNT_W bits whenever it is kept.
  always_comb begin
    rem_sh   = {rem, dividend[NW-1]};
    fits     = (rem_sh >= {1'b0, divisor});
    rem_nx   = fits ? (rem_sh[CNT_W-1:0] - divisor) : rem_sh[CNT_W-1:0];
    quo_nx   = {dividend[NW-2:0], fits};
    duty_sat = (quo_nx > NW'(100)) ? 7'd100 : quo_nx[6:0];
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      dividend   <= '0;
      rem        <= '0;
      divisor    <= '0;
      step       <= '0;
      duty_cycle <= '0;
      period     <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE, MEASURE: begin
          if (rise) begin
            if (state == MEASURE) begin
              dividend <= NW'(hcnt) * NW'(100);
              divisor  <= pcnt;
              rem      <= '0;
              step     <= '0;
              state    <= DIVIDE;
            end else begin
              state    <= MEASURE;
            end
          end else if (timeout) begin
            duty_cycle <= s2 ? 7'd100 : 7'd0;
            period     <= '0;
            valid      <= 1'b1;
            state      <= IDLE;
          end
        end
        DIVIDE: begin
          if (rise) begin
            // New period arrived before the result: drop it and restart.
            overrun  <= 1'b1;
            dividend <= NW'(hcnt) * NW'(100);
            divisor  <= pcnt;
            rem      <= '0;
            step     <= '0;
          end else begin
            dividend <= quo_nx;
            rem      <= rem_nx;
            if (step == LAST_STEP) begin
              duty_cycle <= duty_sat;
              period     <= divisor;
              valid      <= 1'b1;
              state      <= MEASURE;
            end else begin
              step <= step + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.duty_cycle = duty_cycle;
  assign bus.period     = period;
  assign bus.valid      = valid;
  assign bus.overrun    = overrun;

endmodule
`default_nettype wire

// File: doc/pwm_decoder.md
# pwm_decoder

Measures the duty cycle of an incoming PWM waveform and reports it as a whole-number percentage on the same 7-bit duty_cycle scale that the motor-control PWM generator consumes. It sits on the receive side of the motor-control path: servo/ESC feedback or external PWM inputs go in, and duty readings come out to the data logger. It uses a synchronizer, edge-triggered period/high-time counters, a sequential restoring divider and a stuck-signal timeout.

## Interface
- CNT_W, 16: width of the period and high-time counters; the maximum measurable period is 2^CNT_W-1 cycles.
- clk  input  1  system clock; all logic is on posedge.
- clr_n  input  1  asynchronous, active-low reset.
- pwm_in  input  1  asynchronous PWM input.
- duty_cycle  output  7  last measured duty cycle, 0..100 percent.
- period  output  CNT_W  last measured period in clk cycles; 0 after a timeout.
- valid  output  1  one-cycle pulse when duty_cycle and period update.
- overrun  output  1  one-cycle pulse when a period is dropped.

Reset: clr_n is asynchronous and active-low, with one clock domain (clk). While clr_n=0, every register is cleared: duty_cycle=0, period=0, valid=0, overrun=0, synchronizer=0, counters=0, state=IDLE.

## Operation
- Synchronizer: two flops, then a third flop for edge detect. rise = s2 & ~s3; fall = ~s2 & s3.
- Counters (saturating at 2^CNT_W-1):
  - pcnt: loads 1 on rise, otherwise increments.
  - hcnt: loads 1 on rise, increments while s2=1, holds otherwise.
  - At a rise, pcnt = P, the cycles since the previous rise, and hcnt = H, the high cycles in that period.
- States:
  - IDLE (no reference edge yet): on rise, go to MEASURE. The counters load as above.
  - MEASURE: on rise, latch H and P, set num = H*100 (CNT_W+7 bits), and go to DIVIDE.
  - DIVIDE: restoring divide num/P, one quotient bit per cycle, N = CNT_W+7 cycles.
    - On the last step, write duty_cycle = min(quotient, 100) and period = P, pulse valid, and go to MEASURE.
    - A rise during DIVIDE aborts the divide, pulses overrun, latches the new H and P, and restarts DIVIDE from step 0.
- Quotient: floor(H*100/P). No rounding.
- Timeout: if pcnt reaches 2^CNT_W-1 in IDLE or MEASURE:
  - write duty_cycle = 100 if s2=1, else 0; write period = 0; pulse valid;
  - reload pcnt to 0 and go to IDLE.
  - While the input stays stuck, this repeats every 2^CNT_W-1 cycles.
- Simultaneous events:
  - Timeout and rise in the same cycle: the rise wins.
  - fall only affects hcnt. A fall with no prior rise is ignored.

## Timing
- A pwm_in transition sampled at edge k appears on s2 at edge k+1. rise/fall are valid in the following cycle.
- Rise detected in cycle t (in MEASURE):
  - DIVIDE occupies cycles t+1..t+N;
  - duty_cycle, period and valid are visible in cycle t+N+1;
  - the state is MEASURE in cycle t+N+1.
  - With CNT_W=16, N=23, so valid appears 24 cycles after the rise-detect cycle.
- Minimum period without overrun: P >= N+1 (24 cycles at the default).
- The first valid measurement needs two rises after reset or after a timeout.
- valid and overrun are never high in the same cycle. Each is high for exactly one cycle per event.
- duty_cycle and period hold their values between valid pulses.
- If clr_n is asserted mid-DIVIDE, outputs clear immediately and the divide result is discarded.

## Test plan
- Reset: hold clr_n=0 with pwm_in toggling -> duty_cycle=0, period=0, valid=0, overrun=0. No valid before the second rise after release.
- Period 100, high 90, repeated -> from the second rise onward, each period gives valid with duty_cycle=90 and period=100, 24 cycles after rise-detect.
- Period 3, high 1 -> overrun on every rise from the third onward, valid never. Then switch to period 300, high 100 -> duty_cycle=33, period=300.
- pwm_in held 1 from reset release -> valid after 65535 cycles with duty_cycle=100, period=0, then repeats. Held 0 -> duty_cycle=0.
- Period 200, high 50, then the rise arrives 5 cycles after a previous rise mid-DIVIDE -> overrun pulse, the divide restarts. The following clean period reports the correct duty.
- Assert clr_n=0 during DIVIDE -> outputs are 0 in the next cycle, with no spurious valid after release.
